// File: rtl/classifier_database_server_if.sv
// Request/response bundle between the inspecting classifier and one stage's database server.
// Carries o_checksum only when CLASSIFIER_DATABASE_CHECKSUM_EN is defined.
interface classifier_database_server_if #(
  parameter int unsigned DATA_WIDTH_12 = 12
);
  logic                     i_database_request;
  logic                     i_ready;
  logic                     i_wr_en;
  logic [DATA_WIDTH_12-1:0] i_wr_addr;
  logic [DATA_WIDTH_12-1:0] i_wr_data;
  logic                     o_valid;
  logic [DATA_WIDTH_12-1:0] o_data;
  logic [DATA_WIDTH_12-1:0] o_index_database;
  logic [DATA_WIDTH_12-1:0] o_index_classifier;
  logic [DATA_WIDTH_12-1:0] o_index_tree;
  logic                     o_end_single_classifier;
  logic                     o_end_tree;
  logic                     o_end_all_classifier;
  logic                     o_end_database;
  logic                     o_busy;
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
  logic [15:0]              o_checksum;
`endif

  modport master (
    output i_database_request, i_ready, i_wr_en, i_wr_addr, i_wr_data,
    input  o_valid, o_data, o_index_database, o_index_classifier, o_index_tree,
           o_end_single_classifier, o_end_tree, o_end_all_classifier, o_end_database,
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
           o_checksum,
`endif
           o_busy
  );

  modport slave (
    input  i_database_request, i_ready, i_wr_en, i_wr_addr, i_wr_data,
    output o_valid, o_data, o_index_database, o_index_classifier, o_index_tree,
           o_end_single_classifier, o_end_tree, o_end_all_classifier, o_end_database,
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
           o_checksum,
`endif
           o_busy
  );
endinterface

// File: rtl/classifier_database_server.sv
// Streams one cascade stage's Haar parameter image from a loadable sync RAM on request.
// Optional running checksum of accepted words: define CLASSIFIER_DATABASE_CHECKSUM_EN.
module classifier_database_server #(
  parameter int unsigned DATA_WIDTH_12            = 12,
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
  parameter int unsigned DATA_WIDTH_16            = 16,
`endif
  parameter int unsigned NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int unsigned NUM_CLASSIFIERS_PER_TREE = 3,
  parameter int unsigned NUM_TREES                = 2
) (
  input logic                          clk_fpga,
  input logic                          reset_fpga,
  classifier_database_server_if.slave  bus
);

  localparam int unsigned W     = DATA_WIDTH_12;
  localparam int unsigned DEPTH =
      NUM_TREES * NUM_CLASSIFIERS_PER_TREE * NUM_PARAM_PER_CLASSIFIER;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StPrime, StStream, StDone} state_e;

  state_e         state_q;
  logic [W-1:0]   param_q;
  logic [W-1:0]   cls_q;
  logic [W-1:0]   tree_q;
  logic [W-1:0]   db_q;
  logic           valid_q;
  logic           end_db_q;
  logic           busy_q;
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
  logic [DATA_WIDTH_16-1:0] checksum_q;
`endif

  logic [W-1:0]   mem [DEPTH];
  logic [W-1:0]   rd_data_q;
  logic [W-1:0]   rd_addr;
  logic           accept;
  logic           wr_ok;
  logic           last_param;
  logic           last_cls;
  logic           last_tree;
  logic           last_word;

  always_comb begin
    accept     = valid_q & bus.i_ready;
    wr_ok      = (state_q == StIdle) && bus.i_wr_en && (bus.i_wr_addr < W'(DEPTH));
    last_param = (param_q == W'(NUM_PARAM_PER_CLASSIFIER - 1));
    last_cls   = (cls_q == W'(NUM_CLASSIFIERS_PER_TREE - 1));
    last_tree  = (tree_q == W'(NUM_TREES - 1));
    last_word  = (db_q == W'(DEPTH - 1));
    // Counters sit at 0 in IDLE/PRIME, so word 0 is fetched there; stalls re-read in place.
    rd_addr    = db_q;
    if (state_q == StStream && accept && !last_word) begin
      rd_addr = db_q + W'(1);
    end
  end

  // Write-first: a load hitting the address being read is returned in the same cycle.
  always_ff @(posedge clk_fpga) begin
    if (wr_ok) begin
      mem[bus.i_wr_addr[AW-1:0]] <= bus.i_wr_data;
    end
    if (wr_ok && bus.i_wr_addr == rd_addr) begin
      rd_data_q <= bus.i_wr_data;
    end else begin
      rd_data_q <= mem[rd_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q    <= StIdle;
      param_q    <= '0;
      cls_q      <= '0;
      tree_q     <= '0;
      db_q       <= '0;
      valid_q    <= 1'b0;
      end_db_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      end_db_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_database_request) begin
            state_q    <= StPrime;
            busy_q     <= 1'b1;
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
            checksum_q <= '0;
`endif
          end
        end
        StPrime: begin
          if (!bus.i_database_request) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StStream;
            valid_q <= 1'b1;
          end
        end
        StStream: begin
          if (!bus.i_database_request) begin
            // Abort: no end-of-database pulse, counters return to word 0.
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            param_q <= '0;
            cls_q   <= '0;
            tree_q  <= '0;
            db_q    <= '0;
          end else if (accept) begin
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
            checksum_q <= checksum_q + DATA_WIDTH_16'(rd_data_q);
`endif
            if (last_word) begin
              state_q  <= StDone;
              valid_q  <= 1'b0;
              end_db_q <= 1'b1;
            end else begin
              db_q    <= db_q + W'(1);
              param_q <= last_param ? '0 : param_q + W'(1);
              if (last_param) begin
                cls_q <= last_cls ? '0 : cls_q + W'(1);
                if (last_cls) begin
                  tree_q <= tree_q + W'(1);
                end
              end
            end
          end
        end
        StDone: begin
          if (!bus.i_database_request) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            param_q <= '0;
            cls_q   <= '0;
            tree_q  <= '0;
            db_q    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_valid                 = valid_q;
  assign bus.o_data                  = valid_q ? rd_data_q : '0;
  assign bus.o_index_database        = db_q;
  assign bus.o_index_classifier      = cls_q;
  assign bus.o_index_tree            = tree_q;
  assign bus.o_end_single_classifier = valid_q & last_param;
  assign bus.o_end_tree              = valid_q & last_param & last_cls;
  assign bus.o_end_all_classifier    = valid_q & last_param & last_cls & last_tree;
  assign bus.o_end_database          = end_db_q;
  assign bus.o_busy                  = busy_q;
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
  assign bus.o_checksum              = checksum_q;
`endif

endmodule

// File: tb/tb_classifier_database_server.sv
// Directed bench for classifier_database_server: full, stalled, aborted and reset streams,
// load-port protection and write-first behaviour; checksum checked when the macro is defined.
module tb_classifier_database_server;

  localparam int DEPTH = 108;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  classifier_database_server_if bus ();

  classifier_database_server dut (
    .clk_fpga   (clk),
    .reset_fpga (rst),
    .bus        (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {valid, data, db, classifier, tree, end_single, end_tree, end_all, end_database}
  function automatic logic [52:0] observed();
    return {bus.o_valid, bus.o_data, bus.o_index_database, bus.o_index_classifier,
            bus.o_index_tree, bus.o_end_single_classifier, bus.o_end_tree,
            bus.o_end_all_classifier, bus.o_end_database};
  endfunction

  // Image loaded as RAM[n] = n+1; 18 params per classifier, 3 classifiers per tree.
  function automatic logic [52:0] exp_word(input int n);
    return {1'b1, 12'(n + 1), 12'(n), 12'((n / 18) % 3), 12'(n / 54),
            (n % 18) == 17, (n % 54) == 53, n == 107, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.i_database_request = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
    tick();
    tick();
    checks++;
    if ({observed(), bus.o_busy} !== 54'd0)
      $display("FAIL reset_state got %h want 0", {observed(), bus.o_busy});
    rst = 1'b0;
    tick();
    checks++;
    if ({observed(), bus.o_busy} !== 54'd0)
      $display("FAIL idle_after_reset got %h want 0", {observed(), bus.o_busy});
    if (errors == 0 && checks == 2) begin end
  endtask

  task automatic load_ram();
    for (int n = 0; n < DEPTH; n++) begin
      bus.i_wr_en = 1'b1;
      bus.i_wr_addr = 12'(n);
      bus.i_wr_data = 12'(n + 1);
      tick();
    end
    bus.i_wr_en = 1'b0;
  endtask

  task automatic drop_request();
    bus.i_database_request = 1'b0;
    bus.i_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stream(input bit toggle, input bit poke, input string name);
    int n = 0;
    int k = 0;
    bit rdy;
    bus.i_ready = 1'b1;
    bus.i_database_request = 1'b1;
    tick();
    checks++;
    if ({bus.o_valid, bus.o_busy} !== 2'b01) begin
      errors++;
      $display("FAIL %s prime got valid,busy=%b want 01", name, {bus.o_valid, bus.o_busy});
    end
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
    checks++;
    if (bus.o_checksum !== 16'h0000) begin
      errors++;
      $display("FAIL %s checksum_clear got %h want 0000", name, bus.o_checksum);
    end
`endif
    tick();
    while (n < DEPTH && k < 400) begin
      checks++;
      if (observed() !== exp_word(n)) begin
        errors++;
        $display("FAIL %s word%0d cyc%0d got %h want %h", name, n, k, observed(), exp_word(n));
      end
      rdy = toggle ? (k % 2 == 0) : 1'b1;
      bus.i_ready = rdy;
      bus.i_wr_en = poke && (k == 0);
      bus.i_wr_addr = 12'd5;
      bus.i_wr_data = 12'hABC;
      tick();
      if (rdy) n++;
      k++;
    end
    bus.i_wr_en = 1'b0;
    checks++;
    if (k >= 400) begin
      errors++;
      $display("FAIL %s timeout got %0d words want %0d", name, n, DEPTH);
    end
    checks++;
    if ({bus.o_valid, bus.o_end_database, bus.o_busy} !== 3'b011) begin
      errors++;
      $display("FAIL %s done_pulse got %b want 011", name,
               {bus.o_valid, bus.o_end_database, bus.o_busy});
    end
`ifdef CLASSIFIER_DATABASE_CHECKSUM_EN
    checks++;
    if (bus.o_checksum !== 16'h16FE) begin
      errors++;
      $display("FAIL %s checksum got %h want 16fe", name, bus.o_checksum);
    end
`endif
  endtask

  task automatic test_hold_done();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.o_valid, bus.o_end_database, bus.o_busy} !== 3'b001) begin
        errors++;
        $display("FAIL hold_done cyc%0d got %b want 001", i,
                 {bus.o_valid, bus.o_end_database, bus.o_busy});
      end
    end
    bus.i_database_request = 1'b0;
    tick();
    checks++;
    if ({bus.o_busy, bus.o_index_database} !== 13'd0) begin
      errors++;
      $display("FAIL done_to_idle got %h want 0", {bus.o_busy, bus.o_index_database});
    end
    tick();
    test_stream(1'b0, 1'b0, "repeat");
    drop_request();
  endtask

  task automatic test_abort();
    int k = 0;
    bus.i_ready = 1'b1;
    bus.i_database_request = 1'b1;
    tick();
    tick();
    while (bus.o_index_database < 12'd40 && k < 100) begin
      tick();
      k++;
    end
    checks++;
    if ({bus.o_valid, bus.o_index_database, bus.o_data} !== {1'b1, 12'd40, 12'd41}) begin
      errors++;
      $display("FAIL abort_reach got %h want %h", {bus.o_valid, bus.o_index_database, bus.o_data},
               {1'b1, 12'd40, 12'd41});
    end
    bus.i_database_request = 1'b0;
    tick();
    checks++;
    if ({bus.o_valid, bus.o_busy, bus.o_end_database, bus.o_index_database} !== 15'd0) begin
      errors++;
      $display("FAIL abort_idle got %h want 0",
               {bus.o_valid, bus.o_busy, bus.o_end_database, bus.o_index_database});
    end
    tick();
    checks++;
    if (bus.o_end_database !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_end got %b want 0", bus.o_end_database);
    end
    bus.i_database_request = 1'b1;
    tick();
    tick();
    checks++;
    if (observed() !== exp_word(0)) begin
      errors++;
      $display("FAIL abort_restart got %h want %h", observed(), exp_word(0));
    end
    drop_request();
  endtask

  task automatic test_write_drop();
    test_stream(1'b0, 1'b1, "wr_in_stream");
    drop_request();
    bus.i_wr_en = 1'b1;
    bus.i_wr_addr = 12'd200;
    bus.i_wr_data = 12'hFFF;
    tick();
    bus.i_wr_en = 1'b0;
    test_stream(1'b0, 1'b0, "after_drop");
    drop_request();
  endtask

  task automatic test_write_first();
    bus.i_wr_en = 1'b1;
    bus.i_wr_addr = 12'd0;
    bus.i_wr_data = 12'h777;
    bus.i_ready = 1'b0;
    bus.i_database_request = 1'b1;
    tick();
    bus.i_wr_en = 1'b0;
    tick();
    checks++;
    if ({bus.o_valid, bus.o_data, bus.o_index_database} !== {1'b1, 12'h777, 12'd0}) begin
      errors++;
      $display("FAIL write_first got %h want %h", {bus.o_valid, bus.o_data, bus.o_index_database},
               {1'b1, 12'h777, 12'd0});
    end
    drop_request();
    bus.i_wr_en = 1'b1;
    bus.i_wr_data = 12'd1;
    tick();
    bus.i_wr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b1;
    bus.i_database_request = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    bus.i_database_request = 1'b0;
    tick();
    checks++;
    if ({observed(), bus.o_busy} !== 54'd0) begin
      errors++;
      $display("FAIL reset_mid got %h want 0", {observed(), bus.o_busy});
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    load_ram();
    test_stream(1'b0, 1'b0, "full");
    test_hold_done();
    test_stream(1'b1, 1'b0, "stall");
    drop_request();
    test_abort();
    test_write_drop();
    test_write_first();
    test_stream(1'b0, 1'b0, "restored");
    drop_request();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
